// File: rtl/imem_loader_pkg.sv
// Shared loader constants, state encoding and status decode.
// Imported by the loader top and its checksum helper.
package imem_loader_pkg;

    localparam int WORD_LEN       = 32;
    localparam int MEM_CELL_SIZE  = 8;
    localparam int INSTR_MEM_SIZE = 1024;

    typedef enum logic [2:0] {
        LD_IDLE   = 3'd0,
        LD_LEN_HI = 3'd1,
        LD_LEN_LO = 3'd2,
        LD_LOAD   = 3'd3,
        LD_CHK    = 3'd4,
        LD_DONE   = 3'd5,
        LD_ERR    = 3'd6
    } ld_state_t;

    typedef struct packed {
        logic busy;
        logic stall;
        logic done;
        logic err;
    } ld_flags_t;

    // Status outputs implied by being in a given state.
    function automatic ld_flags_t flags_of(ld_state_t s);
        ld_flags_t f;
        f = '0;
        unique case (s)
            LD_LEN_HI, LD_LEN_LO, LD_LOAD, LD_CHK: begin
                f.busy  = 1'b1;
                f.stall = 1'b1;
            end
            LD_ERR: begin
                f.stall = 1'b1;
                f.err   = 1'b1;
            end
            LD_DONE: f.done = 1'b1;
            default: f = '0;
        endcase
        return f;
    endfunction

    // A usable image is non-empty, whole words, and fits the memory.
    function automatic logic len_ok(logic [15:0] n, int mem_size);
        return (n != 16'd0) && (n[1:0] == 2'b00) && (int'(n) <= mem_size);
    endfunction

endpackage

// File: rtl/imem_loader_xor_checksum.sv
// Running XOR over the payload bytes of one load session.
// Cleared at session start and by reset.
module imem_loader_xor_checksum (
    input  logic       clk,
    input  logic       rst,
    input  logic       clr,
    input  logic       en,
    input  logic [7:0] din,
    output logic [7:0] sum
);

    // Accumulate accepted payload bytes.
    always_ff @(posedge clk) begin
        if (rst || clr) begin
            sum <= 8'h00;
        end else if (en) begin
            sum <= sum ^ din;
        end
    end

endmodule

// File: rtl/imem_loader.sv
// Streams a length-prefixed, XOR-checked image into instruction memory,
// holding the CPU stalled while the memory is being rewritten.
module imem_loader
    import imem_loader_pkg::*;
#(
    parameter int MEM_SIZE = INSTR_MEM_SIZE,
    parameter int CELL_W   = MEM_CELL_SIZE
) (
    input  logic                        clk,
    input  logic                        rst,
    input  logic                        start,
    input  logic                        in_valid,
    input  logic [CELL_W-1:0]           in_data,
    output logic                        in_ready,
    output logic                        mem_we,
    output logic [$clog2(MEM_SIZE)-1:0] mem_waddr,
    output logic [CELL_W-1:0]           mem_wdata,
    output logic                        cpu_stall,
    output logic                        pc_rst,
    output logic                        busy,
    output logic                        done,
    output logic                        err
);

    localparam int AW = $clog2(MEM_SIZE);
    // One extra bit so a full-memory image counts up to MEM_SIZE cleanly.
    localparam int CW = AW + 1;

    ld_state_t       state;
    ld_flags_t       flags;
    logic [7:0]      len_hi;
    logic [CW-1:0]   len;
    logic [CW-1:0]   cnt;
    logic [CW-1:0]   cnt_n;
    logic [15:0]     len_n;
    logic [7:0]      sum;
    logic            xfer;
    logic            idle_like;
    logic            clr_sum;
    logic            en_sum;

    assign idle_like = (state == LD_IDLE) || (state == LD_DONE) ||
                       (state == LD_ERR);
    assign xfer      = in_valid & in_ready;
    assign cnt_n     = cnt + CW'(1);
    assign len_n     = {len_hi, in_data[7:0]};
    assign clr_sum   = idle_like & start;
    assign en_sum    = xfer & (state == LD_LOAD);

    // Reset must also suppress a write that coincides with it.
    assign mem_we    = xfer & (state == LD_LOAD) & ~rst;
    assign mem_waddr = cnt[AW-1:0];
    assign mem_wdata = mem_we ? in_data : '0;

    assign in_ready  = flags.busy;
    assign busy      = flags.busy;
    assign cpu_stall = flags.stall;
    assign done      = flags.done;
    assign err       = flags.err;

    imem_loader_xor_checksum u_csum (
        .clk (clk),
        .rst (rst),
        .clr (clr_sum),
        .en  (en_sum),
        .din (in_data[7:0]),
        .sum (sum)
    );

    // Session FSM with byte counter; status flags registered with the state.
    always_ff @(posedge clk) begin
        if (rst) begin
            state  <= LD_IDLE;
            flags  <= '0;
            cnt    <= '0;
            len    <= '0;
            len_hi <= 8'h00;
            pc_rst <= 1'b0;
        end else begin
            pc_rst <= 1'b0;
            unique case (state)
                LD_IDLE, LD_DONE, LD_ERR: begin
                    if (start) begin
                        state <= LD_LEN_HI;
                        flags <= flags_of(LD_LEN_HI);
                        cnt   <= '0;
                    end
                end
                LD_LEN_HI: begin
                    if (xfer) begin
                        len_hi <= in_data[7:0];
                        state  <= LD_LEN_LO;
                        flags  <= flags_of(LD_LEN_LO);
                    end
                end
                LD_LEN_LO: begin
                    if (xfer) begin
                        if (len_ok(len_n, MEM_SIZE)) begin
                            len   <= CW'(len_n);
                            state <= LD_LOAD;
                            flags <= flags_of(LD_LOAD);
                        end else begin
                            state <= LD_ERR;
                            flags <= flags_of(LD_ERR);
                        end
                    end
                end
                LD_LOAD: begin
                    if (xfer) begin
                        cnt <= cnt_n;
                        if (cnt_n == len) begin
                            state <= LD_CHK;
                            flags <= flags_of(LD_CHK);
                        end
                    end
                end
                LD_CHK: begin
                    if (xfer) begin
                        if (in_data[7:0] == sum) begin
                            state  <= LD_DONE;
                            flags  <= flags_of(LD_DONE);
                            pc_rst <= 1'b1;
                        end else begin
                            state <= LD_ERR;
                            flags <= flags_of(LD_ERR);
                        end
                    end
                end
                default: begin
                    state <= LD_IDLE;
                    flags <= '0;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_imem_loader.sv
// Scoreboard bench for imem_loader: expected writes queued as bytes
// are driven, checked against mem_we activity on the falling edge.
module tb_imem_loader;

    localparam int MS = 64;
    localparam int AW = $clog2(MS);

    logic          clk = 1'b0;
    logic          rst;
    logic          start;
    logic          in_valid;
    logic [7:0]    in_data;
    logic          in_ready;
    logic          mem_we;
    logic [AW-1:0] mem_waddr;
    logic [7:0]    mem_wdata;
    logic          cpu_stall;
    logic          pc_rst;
    logic          busy;
    logic          done;
    logic          err;

    imem_loader #(
        .MEM_SIZE (MS),
        .CELL_W   (8)
    ) dut (
        .clk       (clk),
        .rst       (rst),
        .start     (start),
        .in_valid  (in_valid),
        .in_data   (in_data),
        .in_ready  (in_ready),
        .mem_we    (mem_we),
        .mem_waddr (mem_waddr),
        .mem_wdata (mem_wdata),
        .cpu_stall (cpu_stall),
        .pc_rst    (pc_rst),
        .busy      (busy),
        .done      (done),
        .err       (err)
    );

    always #5 clk = ~clk;

    int              n_run = 0;
    int              n_fail = 0;
    int              wr_cnt = 0;
    int              pc_cnt = 0;
    logic [AW-1:0]   last_addr = '0;
    logic [AW+7:0]   exp_q[$];
    logic [7:0]      payload[$];

    task automatic chk(input string tag, input logic [31:0] got,
                       input logic [31:0] exp);
        n_run++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
        end
    endtask

    // Write monitor / scoreboard consumer.
    always @(negedge clk) begin
        if (mem_we) begin
            wr_cnt++;
            last_addr = mem_waddr;
            if (exp_q.size() == 0) begin
                chk("wr_extra", 32'd1, 32'd0);
            end else begin
                chk("wr", 32'({mem_waddr, mem_wdata}), 32'(exp_q.pop_front()));
            end
        end
        if (pc_rst) pc_cnt++;
    end

    task automatic send(input logic [7:0] b, input bit gap, input bit rdy_gap);
        int i;
        i = 0;
        in_valid = 1'b1;
        in_data  = b;
        @(negedge clk);
        while (!in_ready && i < 20) begin
            @(negedge clk);
            i++;
        end
        if (!in_ready) chk("rdy_timeout", 32'd0, 32'd1);
        @(posedge clk);
        #1;
        in_valid = 1'b0;
        if (gap) begin
            in_data = 8'($urandom);
            @(negedge clk);
            if (rdy_gap) chk("rdy_gap", 32'(in_ready), 32'd1);
            @(posedge clk);
            #1;
        end
    endtask

    task automatic pulse_start();
        start = 1'b1;
        @(posedge clk);
        #1;
        start = 1'b0;
    endtask

    task automatic run_load(input logic [7:0] csum, input bit gap);
        int n;
        n = payload.size();
        pulse_start();
        send(n[15:8], gap, 1'b1);
        send(n[7:0], gap, 1'b1);
        for (int k = 0; k < n; k++) begin
            exp_q.push_back({AW'(k), payload[k]});
            send(payload[k], gap, 1'b1);
        end
        send(csum, 1'b0, 1'b0);
    endtask

    task automatic check_done(input string t, input int w0, input int p0,
                              input int nw);
        @(negedge clk);
        chk({t, "_done"}, 32'(done), 32'd1);
        chk({t, "_pcrst"}, 32'(pc_rst), 32'd1);
        chk({t, "_stall"}, 32'(cpu_stall), 32'd0);
        chk({t, "_busy"}, 32'(busy), 32'd0);
        @(negedge clk);
        chk({t, "_pcrst_off"}, 32'(pc_rst), 32'd0);
        chk({t, "_writes"}, 32'(wr_cnt - w0), 32'(nw));
        chk({t, "_pccnt"}, 32'(pc_cnt - p0), 32'd1);
        chk({t, "_q"}, 32'(exp_q.size()), 32'd0);
    endtask

    task automatic check_idle(input string t);
        chk({t, "_rdy"}, 32'(in_ready), 32'd0);
        chk({t, "_flags"}, 32'({busy, done, err, cpu_stall, pc_rst}), 32'd0);
        chk({t, "_we"}, 32'({mem_we, mem_waddr, mem_wdata}), 32'd0);
    endtask

    logic [15:0] bad_len[5] = '{16'h0006, 16'h0000, 16'h0044,
                                16'h0041, 16'h0002};

    initial begin
        int w0;
        int p0;
        rst      = 1'b1;
        start    = 1'b0;
        in_valid = 1'b0;
        in_data  = 8'h00;
        repeat (3) @(posedge clk);
        #1;
        @(negedge clk);
        check_idle("reset");
        @(posedge clk);
        #1;
        rst = 1'b0;

        payload = '{8'h80, 8'hA0, 8'h00, 8'h08, 8'h90, 8'h20, 8'h00, 8'h00};

        // Good image, continuous stream.
        w0 = wr_cnt; p0 = pc_cnt;
        run_load(8'h98, 1'b0);
        check_done("A", w0, p0, 8);

        // Bad checksum, then recover; second start lands while busy.
        w0 = wr_cnt; p0 = pc_cnt;
        run_load(8'h99, 1'b0);
        @(negedge clk);
        chk("B_err", 32'(err), 32'd1);
        chk("B_stall", 32'(cpu_stall), 32'd1);
        chk("B_done", 32'(done), 32'd0);
        chk("B_rdy", 32'(in_ready), 32'd0);
        @(negedge clk);
        chk("B_pccnt", 32'(pc_cnt - p0), 32'd0);
        chk("B_writes", 32'(wr_cnt - w0), 32'd8);
        pulse_start();
        @(negedge clk);
        chk("B_restart", 32'({busy, err}), 32'b10);
        w0 = wr_cnt; p0 = pc_cnt;
        run_load(8'h98, 1'b0);
        check_done("B2", w0, p0, 8);

        // Illegal headers.
        foreach (bad_len[i]) begin
            w0 = wr_cnt;
            pulse_start();
            send(bad_len[i][15:8], 1'b0, 1'b0);
            send(bad_len[i][7:0], 1'b0, 1'b0);
            @(negedge clk);
            chk("C_err", 32'(err), 32'd1);
            chk("C_writes", 32'(wr_cnt - w0), 32'd0);
        end

        // Same good image with a bubble after every byte.
        w0 = wr_cnt; p0 = pc_cnt;
        run_load(8'h98, 1'b1);
        check_done("D", w0, p0, 8);

        // Reset after third payload byte, colliding with a fourth.
        w0 = wr_cnt;
        pulse_start();
        send(8'h00, 1'b0, 1'b0);
        send(8'h08, 1'b0, 1'b0);
        for (int k = 0; k < 3; k++) begin
            exp_q.push_back({AW'(k), payload[k]});
            send(payload[k], 1'b0, 1'b0);
        end
        rst      = 1'b1;
        in_valid = 1'b1;
        in_data  = 8'h55;
        @(posedge clk);
        #1;
        rst      = 1'b0;
        in_valid = 1'b0;
        @(negedge clk);
        check_idle("E");
        chk("E_writes", 32'(wr_cnt - w0), 32'd3);
        chk("E_q", 32'(exp_q.size()), 32'd0);

        // Full-memory image.
        payload.delete();
        for (int k = 0; k < MS; k++) payload.push_back(8'h5A);
        w0 = wr_cnt; p0 = pc_cnt;
        run_load(8'h00, 1'b0);
        check_done("F", w0, p0, MS);
        chk("F_last", 32'(last_addr), 32'(MS - 1));

        $display("[TB] %0d tests run, %0d failed", n_run, n_fail);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL watchdog got=timeout exp=finish");
        $fatal(1, "watchdog");
    end

endmodule
